z_history_writer: RTL and testbench

Writer side of the z / z_prev memory pair consumed by the ADMM residual calculator. For each ADMM iteration, the block accepts the freshly computed slack vector z as a stream of elements. For each element it reads the old z entry, copies it into z_prev, and overwrites z with the new value. It sits between the slack-update stage and the residual calculator, and must assert done before the residual calculator is started.

---
 rtl/z_history_writer_pkg.sv | 20 ++
 rtl/z_history_writer_addr_gen.sv | 51 +++++
 rtl/z_history_writer.sv | 173 +++++++++++++++++
 tb/tb_z_history_writer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/z_history_writer_pkg.sv
// Shared types and ADMM dimension constants for the z / z_prev history writer
// and the residual calculator that reads the same memories.
package z_history_writer_pkg;

    localparam int ADMM_INPUT_DIM        = 4;
    localparam int ADMM_HORIZON          = 30;
    localparam int ADMM_DATA_WIDTH_STATE = 192;
    // Width of the u / input-side vectors used alongside z by the residual stage.
    localparam int ADMM_DATA_WIDTH_INPUT = 64;
    localparam int ADMM_ADDR_WIDTH       = 9;

    typedef enum logic [2:0] {
        ZHW_IDLE,
        ZHW_ACCEPT,
        ZHW_WAIT,
        ZHW_COMMIT,
        ZHW_DONE
    } zhw_state_t;

endpackage

// File: rtl/z_history_writer_addr_gen.sv
// Element-total computation (horizon clamp) and the linear index counter with
// its last-element flag for the z history writer.
module zhw_addr_gen #(
    parameter int INPUT_DIM  = 4,
    parameter int HORIZON    = 30,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           active_horizon,
    input  logic                  load,
    input  logic                  step,
    output logic                  total_zero,
    output logic [ADDR_WIDTH-1:0] idx,
    output logic                  last
);

    localparam int CW = ADDR_WIDTH + 1;

    logic [31:0]           h_clamped;
    logic [CW-1:0]         total_calc;
    logic [CW-1:0]         total_reg;
    logic [ADDR_WIDTH-1:0] idx_reg;

    // One step fewer than the horizon: matches the residual calculator's scan range.
    always_comb begin
        h_clamped = (active_horizon > 32'(HORIZON)) ? 32'(HORIZON) : active_horizon;
        if (h_clamped <= 32'd1) begin
            total_calc = '0;
        end else begin
            total_calc = (CW'(h_clamped) - CW'(1)) * CW'(INPUT_DIM);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_reg <= '0;
            idx_reg   <= '0;
        end else if (load) begin
            total_reg <= total_calc;
            idx_reg   <= '0;
        end else if (step) begin
            idx_reg <= idx_reg + ADDR_WIDTH'(1);
        end
    end

    assign total_zero = (total_calc == '0);
    assign idx        = idx_reg;
    assign last       = ({1'b0, idx_reg} == (total_reg - CW'(1)));

endmodule

// File: rtl/z_history_writer.sv
// Writer for the z / z_prev memory pair: per element, old z is copied to z_prev
// and z is overwritten with the streamed value. Optional macro: Z_PREV_SEED_EN.
module z_history_writer
    import z_history_writer_pkg::*;
#(
    parameter int INPUT_DIM        = ADMM_INPUT_DIM,
    parameter int HORIZON          = ADMM_HORIZON,
    parameter int DATA_WIDTH_STATE = ADMM_DATA_WIDTH_STATE,
    parameter int ADDR_WIDTH       = ADMM_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
`ifdef Z_PREV_SEED_EN
    input  logic                        first_iter,
`endif
    input  logic [31:0]                 active_horizon,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH_STATE-1:0] in_data,
    output logic [ADDR_WIDTH-1:0]       z_rdaddress,
    input  logic [DATA_WIDTH_STATE-1:0] z_data_out,
    output logic [ADDR_WIDTH-1:0]       z_wraddress,
    output logic                        z_wren,
    output logic [DATA_WIDTH_STATE-1:0] z_data_in,
    output logic [ADDR_WIDTH-1:0]       z_prev_wraddress,
    output logic                        z_prev_wren,
    output logic [DATA_WIDTH_STATE-1:0] z_prev_data_in,
    output logic                        busy,
    output logic                        done,
    output logic [ADDR_WIDTH:0]         elem_count
);

    localparam int CW = ADDR_WIDTH + 1;

    zhw_state_t                  state_reg, state_next;
    logic [DATA_WIDTH_STATE-1:0] new_reg;
    logic [ADDR_WIDTH-1:0]       rdaddr_reg;
    logic [ADDR_WIDTH-1:0]       wraddr_reg;
    logic                        wren_reg, wren_next;
    logic                        busy_reg, busy_next;
    logic                        done_reg, done_next;
    logic [CW-1:0]               count_reg, count_next;
    logic                        load;
    logic                        step;
    logic                        handshake;
    logic                        total_zero;
    logic                        last;
    logic [ADDR_WIDTH-1:0]       idx;

    zhw_addr_gen #(
        .INPUT_DIM  (INPUT_DIM),
        .HORIZON    (HORIZON),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk            (clk),
        .rst            (rst),
        .active_horizon (active_horizon),
        .load           (load),
        .step           (step),
        .total_zero     (total_zero),
        .idx            (idx),
        .last           (last)
    );

    assign handshake = (state_reg == ZHW_ACCEPT) && in_valid;

    always_comb begin
        state_next = state_reg;
        wren_next  = 1'b0;
        busy_next  = busy_reg;
        done_next  = done_reg;
        count_next = count_reg;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            ZHW_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    busy_next  = 1'b1;
                    done_next  = 1'b0;
                    count_next = '0;
                    state_next = total_zero ? ZHW_DONE : ZHW_ACCEPT;
                end
            end
            ZHW_ACCEPT: begin
                if (in_valid) begin
                    state_next = ZHW_WAIT;
                end
            end
            ZHW_WAIT: begin
                wren_next  = 1'b1;
                state_next = ZHW_COMMIT;
            end
            ZHW_COMMIT: begin
                step       = 1'b1;
                count_next = count_reg + CW'(1);
                if (last) begin
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = ZHW_DONE;
                end else begin
                    state_next = ZHW_ACCEPT;
                end
            end
            ZHW_DONE: begin
                busy_next = 1'b0;
                done_next = 1'b1;
                // Only leave once done has actually been visible to the requester.
                if (!start && done_reg) begin
                    done_next  = 1'b0;
                    state_next = ZHW_IDLE;
                end
            end
            default: begin
                state_next = ZHW_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ZHW_IDLE;
            wren_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            count_reg  <= '0;
            new_reg    <= '0;
            rdaddr_reg <= '0;
            wraddr_reg <= '0;
        end else begin
            state_reg <= state_next;
            wren_reg  <= wren_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            count_reg <= count_next;
            if (handshake) begin
                new_reg    <= in_data;
                rdaddr_reg <= idx;
                wraddr_reg <= idx;
            end
        end
    end

`ifdef Z_PREV_SEED_EN
    logic seed_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_reg <= 1'b0;
        end else if (state_reg == ZHW_IDLE && start) begin
            seed_reg <= first_iter;
        end
    end

    // Seeding z_prev with the new value makes the first dual residual zero.
    assign z_prev_data_in = wren_reg ? (seed_reg ? new_reg : z_data_out) : '0;
`else
    assign z_prev_data_in = wren_reg ? z_data_out : '0;
`endif

    assign in_ready         = (state_reg == ZHW_ACCEPT);
    assign z_rdaddress      = rdaddr_reg;
    assign z_wraddress      = wraddr_reg;
    assign z_prev_wraddress = wraddr_reg;
    assign z_wren           = wren_reg;
    assign z_prev_wren      = wren_reg;
    assign z_data_in        = new_reg;
    assign busy             = busy_reg;
    assign done             = done_reg;
    assign elem_count       = count_reg;

endmodule

// File: tb/tb_z_history_writer.sv
// Scoreboard bench for z_history_writer with behavioural z / z_prev memories.
module tb_z_history_writer;

    localparam int DW = 192;
    localparam int AW = 9;

    logic          clk;
    logic          rst;
    logic          start;
    logic          first_iter;
    logic [31:0]   active_horizon;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [AW-1:0] z_rdaddress;
    logic [DW-1:0] z_data_out;
    logic [AW-1:0] z_wraddress;
    logic          z_wren;
    logic [DW-1:0] z_data_in;
    logic [AW-1:0] z_prev_wraddress;
    logic          z_prev_wren;
    logic [DW-1:0] z_prev_data_in;
    logic          busy;
    logic          done;
    logic [AW:0]   elem_count;

    z_history_writer dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
`ifdef Z_PREV_SEED_EN
        .first_iter       (first_iter),
`endif
        .active_horizon   (active_horizon),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .z_rdaddress      (z_rdaddress),
        .z_data_out       (z_data_out),
        .z_wraddress      (z_wraddress),
        .z_wren           (z_wren),
        .z_data_in        (z_data_in),
        .z_prev_wraddress (z_prev_wraddress),
        .z_prev_wren      (z_prev_wren),
        .z_prev_data_in   (z_prev_data_in),
        .busy             (busy),
        .done             (done),
        .elem_count       (elem_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memories: one-register synchronous read.
    logic [DW-1:0] z_mem  [512];
    logic [DW-1:0] zp_mem [512];
    logic [DW-1:0] z_rd_q;
    logic          preload_en;
    logic [DW-1:0] pre_z_base;
    logic [DW-1:0] pre_zp_base;

    assign z_data_out = z_rd_q;

    always @(posedge clk) begin
        z_rd_q <= z_mem[z_rdaddress];
        if (preload_en) begin
            for (int i = 0; i < 512; i++) begin
                z_mem[i]  <= pre_z_base + DW'(i);
                zp_mem[i] <= pre_zp_base + DW'(i);
            end
        end else begin
            if (z_wren)      z_mem[z_wraddress]       <= z_data_in;
            if (z_prev_wren) zp_mem[z_prev_wraddress] <= z_prev_data_in;
        end
    end

    typedef struct {
        int            addr;
        logic [DW-1:0] nw;
        logic [DW-1:0] old;
        logic [DW-1:0] oldp;
        logic [DW-1:0] exp_prev;
        int            cyc;
    } sb_entry_t;

    sb_entry_t     sb_q[$];
    logic [DW-1:0] mz  [512];
    logic [DW-1:0] mzp [512];
    int            sb_idx;
    bit            sb_seed;
    int            n_checks;
    int            n_errors;
    int            wr_cnt;
    int            last_wr_addr;
    int            last_wr_cyc;
    int            done_cyc;
    int            busy_cyc;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand192();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic int calc_t(input int ah);
        int h;
        h = (ah > 30) ? 30 : ah;
        return (h <= 1) ? 0 : (h - 1) * 4;
    endfunction

    task automatic monitor();
        sb_entry_t e;
        bit done_q = 1'b0;
        bit busy_q = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = sb_q.size() - 1; i >= 0; i--) begin
                    mz[sb_q[i].addr]  = sb_q[i].old;
                    mzp[sb_q[i].addr] = sb_q[i].oldp;
                end
                sb_q.delete();
                done_q = 1'b0;
                busy_q = 1'b0;
                continue;
            end
            if (in_valid && in_ready) begin
                e.addr     = sb_idx;
                e.nw       = in_data;
                e.old      = mz[sb_idx];
                e.oldp     = mzp[sb_idx];
                e.exp_prev = sb_seed ? in_data : mz[sb_idx];
                e.cyc      = cyc;
                mzp[sb_idx] = e.exp_prev;
                mz[sb_idx]  = in_data;
                sb_idx++;
                sb_q.push_back(e);
            end
            if (z_wren || z_prev_wren) begin
                wr_cnt++;
                check("wren_pair", DW'(z_wren), DW'(z_prev_wren));
                if (sb_q.size() == 0) begin
                    check("spurious_write", DW'(1), DW'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("z_wraddr", DW'(z_wraddress), DW'(e.addr));
                    check("zp_wraddr", DW'(z_prev_wraddress), DW'(e.addr));
                    check("z_wdata", z_data_in, e.nw);
                    check("zp_wdata", z_prev_data_in, e.exp_prev);
                    check("wr_latency", DW'(cyc), DW'(e.cyc + 2));
                end
                last_wr_addr = int'(z_wraddress);
                last_wr_cyc  = cyc;
            end
            if (done && !done_q) done_cyc = cyc;
            if (busy && !busy_q) busy_cyc = cyc;
            done_q = done;
            busy_q = busy;
        end
    endtask

    task automatic preload(input logic [DW-1:0] zb, input logic [DW-1:0] zpb);
        for (int i = 0; i < 512; i++) begin
            mz[i]  = zb + DW'(i);
            mzp[i] = zpb + DW'(i);
        end
        pre_z_base  = zb;
        pre_zp_base = zpb;
        preload_en  = 1'b1;
        @(posedge clk); #1;
        preload_en = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check("handshake_timeout", DW'(0), DW'(1));
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, DW'(in_ready), DW'(0));
        check({tag, "_z_wren"}, DW'(z_wren), DW'(0));
        check({tag, "_zp_wren"}, DW'(z_prev_wren), DW'(0));
        check({tag, "_done"}, DW'(done), DW'(0));
        check({tag, "_busy"}, DW'(busy), DW'(0));
        check({tag, "_elem_count"}, DW'(elem_count), DW'(0));
        check({tag, "_rdaddr"}, DW'(z_rdaddress), DW'(0));
        check({tag, "_wraddr"}, DW'(z_wraddress), DW'(0));
        check({tag, "_zp_wraddr"}, DW'(z_prev_wraddress), DW'(0));
        check({tag, "_z_wdata"}, z_data_in, DW'(0));
        check({tag, "_zp_wdata"}, z_prev_data_in, DW'(0));
    endtask

    task automatic mem_compare(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_z_mem"}, z_mem[i], mz[i]);
            check({tag, "_zp_mem"}, zp_mem[i], mzp[i]);
        end
    endtask

    // base = 0 streams random data, otherwise base+idx.
    task automatic run_pass(input string tag, input int ah, input int gap,
                            input logic [DW-1:0] base, input bit seed);
        int exp_t;
        int base_wr;
        int start_cyc;
        int n;
        exp_t          = calc_t(ah);
        base_wr        = wr_cnt;
        sb_idx         = 0;
        sb_seed        = seed;
        first_iter     = seed;
        active_horizon = 32'(ah);
        start_cyc      = cyc;
        start          = 1'b1;
        for (int k = 0; k < exp_t; k++) begin
            send((base == '0) ? rand192() : base + DW'(k));
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        n = 0;
        while (!done && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done_seen"}, DW'(done), DW'(1));
        @(negedge clk); #1;
        check({tag, "_elem_count"}, DW'(elem_count), DW'(exp_t));
        check({tag, "_commits"}, DW'(wr_cnt - base_wr), DW'(exp_t));
        check({tag, "_busy_latency"}, DW'(busy_cyc), DW'(start_cyc + 1));
        if (exp_t > 0) check({tag, "_done_latency"}, DW'(done_cyc), DW'(last_wr_cyc + 1));
        else           check({tag, "_done_latency"}, DW'(done_cyc), DW'(start_cyc + 2));
        $display("pass %s: horizon=%0d elements=%0d done_cycle=%0d", tag, ah, elem_count, done_cyc);
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done_cleared"}, DW'(done), DW'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        wr_cnt         = 0;
        sb_idx         = 0;
        sb_seed        = 1'b0;
        last_wr_addr   = -1;
        last_wr_cyc    = 0;
        done_cyc       = 0;
        busy_cyc       = 0;
        rst            = 1'b1;
        start          = 1'b0;
        first_iter     = 1'b0;
        active_horizon = '0;
        in_valid       = 1'b0;
        in_data        = '0;
        preload_en     = 1'b0;
        pre_z_base     = '0;
        pre_zp_base    = '0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Nominal 3-step horizon with the fixed patterns.
        preload(DW'(32'h100), DW'(32'h900));
        run_pass("h3", 3, 0, DW'(32'h200), 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("h3_z", z_mem[i], DW'(32'h200 + i));
            check("h3_zp", zp_mem[i], DW'(32'h100 + i));
        end
        check("h3_z8_untouched", z_mem[8], DW'(32'h108));
        check("h3_zp8_untouched", zp_mem[8], DW'(32'h908));

        // Degenerate horizon: nothing written.
        run_pass("h1", 1, 0, '0, 1'b0);
        run_pass("h0", 0, 0, '0, 1'b0);

        // Horizon beyond the maximum is clamped.
        preload(DW'(32'h1000), DW'(32'h5000));
        run_pass("h40", 40, 0, '0, 1'b0);
        check("h40_last_addr", DW'(last_wr_addr), DW'(115));
        mem_compare("h40", 117);

        // Gapped stream.
        run_pass("gap", 2, 5, '0, 1'b0);
        mem_compare("gap", 9);

        // Reset in the WAIT of element 3.
        preload(DW'(32'h300), DW'(32'h700));
        sb_idx         = 0;
        sb_seed        = 1'b0;
        active_horizon = 32'd3;
        start          = 1'b1;
        for (int k = 0; k < 4; k++) send(DW'(32'h400 + k));
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_zero("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_z3", z_mem[3], DW'(32'h303));
        check("abort_zp3", zp_mem[3], DW'(32'h703));
        check("abort_z2", z_mem[2], DW'(32'h402));
        check("abort_zp2", zp_mem[2], DW'(32'h302));
        run_pass("after_abort", 3, 0, '0, 1'b0);
        mem_compare("after_abort", 9);

`ifdef Z_PREV_SEED_EN
        run_pass("seed", 3, 0, '0, 1'b1);
        mem_compare("seed", 9);
        for (int i = 0; i < 8; i++) check("seed_zp_eq_z", zp_mem[i], z_mem[i]);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
